// File: rtl/load_store_requester_if.sv
// Memory-unit port of the load/store requester.
// Master drives op/addr/in; slave returns registered data and fault.
interface load_store_requester_if;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic [31:0] mem_out;
  logic        mem_fault;

  modport master (
    output mem_op, mem_addr, mem_in,
    input  mem_out, mem_fault
  );

  modport slave (
    input  mem_op, mem_addr, mem_in,
    output mem_out, mem_fault
  );
endinterface

// File: rtl/load_store_requester.sv
// One-at-a-time load/store initiator: address calc, pre-check, issue, extend.
// Optional LSU_UNSIGNED_LOADS_EN enables LBU/LHU (funct3 100/101).
module load_store_requester (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] base_i,
  input  logic [11:0] offset_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        fault_o,
  load_store_requester_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    DONE
  } state_t;

  state_t      state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic        busy_q;
  logic        done_q;
  logic        fault_q;
  logic [31:0] result_q;
  logic [2:0]  mem_op_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_in_q;

  logic [31:0] addr_d;
  logic [1:0]  width_d;
  logic        f3_ok_d;
  logic        misalign_d;
  logic        bad_d;
  logic [31:0] ext_d;

  assign addr_d = base_i + {{20{offset_i[11]}}, offset_i};

  // Decode width and reject bad funct3 or misaligned addresses up front
  always_comb begin
    f3_ok_d = 1'b0;
    width_d = 2'b00;
    unique case (1'b1)
      funct3_i == 3'b000: begin
        f3_ok_d = 1'b1;
        width_d = 2'b00;
      end
      funct3_i == 3'b001: begin
        f3_ok_d = 1'b1;
        width_d = 2'b01;
      end
      funct3_i == 3'b010: begin
        f3_ok_d = 1'b1;
        width_d = 2'b10;
      end
`ifdef LSU_UNSIGNED_LOADS_EN
      funct3_i == 3'b100: begin
        f3_ok_d = ~is_store_i;
        width_d = 2'b00;
      end
      funct3_i == 3'b101: begin
        f3_ok_d = ~is_store_i;
        width_d = 2'b01;
      end
`endif
      default: begin
        f3_ok_d = 1'b0;
        width_d = 2'b00;
      end
    endcase
    misalign_d = ((width_d == 2'b01) && addr_d[0]) ||
                 ((width_d == 2'b10) && (addr_d[1:0] != 2'b00));
    bad_d = ~f3_ok_d | misalign_d;
  end

  // Extend the returned load data according to the latched funct3
  always_comb begin
    ext_d = mem.mem_out;
    unique case (1'b1)
      funct3_q == 3'b000:
        ext_d = {{24{mem.mem_out[7]}}, mem.mem_out[7:0]};
      funct3_q == 3'b001:
        ext_d = {{16{mem.mem_out[15]}}, mem.mem_out[15:0]};
`ifdef LSU_UNSIGNED_LOADS_EN
      funct3_q == 3'b100:
        ext_d = {24'h0, mem.mem_out[7:0]};
      funct3_q == 3'b101:
        ext_d = {16'h0, mem.mem_out[15:0]};
`endif
      default:
        ext_d = mem.mem_out;
    endcase
  end

  // Request FSM; memory port is live only during ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      result_q   <= 32'h0;
      mem_op_q   <= 3'b000;
      mem_addr_q <= 32'h0;
      mem_in_q   <= 32'h0;
    end else begin
      done_q     <= 1'b0;
      mem_op_q   <= 3'b000;
      mem_addr_q <= 32'h0;
      mem_in_q   <= 32'h0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            is_store_q <= is_store_i;
            funct3_q   <= funct3_i;
            busy_q     <= 1'b1;
            if (bad_d) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              fault_q  <= 1'b1;
              result_q <= 32'h0;
            end else begin
              state_q    <= ISSUE;
              mem_op_q   <= {is_store_i, width_d};
              mem_addr_q <= addr_d;
              mem_in_q   <= store_data_i;
            end
          end
        end
        ISSUE: state_q <= RESP;
        RESP: begin
          state_q  <= DONE;
          done_q   <= 1'b1;
          fault_q  <= mem.mem_fault;
          result_q <= (is_store_q || mem.mem_fault) ? 32'h0 : ext_d;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign result_o     = result_q;
  assign fault_o      = fault_q;
  assign mem.mem_op   = mem_op_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_in   = mem_in_q;

endmodule
